pps_timebase: RTL and testbench

//  Downstream consumer of the 1 Hz mark selector: takes its T1hz and FLAG_1Hz outputs (48 MHz domain) into clk125.

---
 rtl/pps_timebase.sv | 178 +++++++++++++++++
 tb/tb_pps_timebase.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pps_timebase.sv
// rtl/pps_timebase.sv - seconds/sub-second timebase at clk125 locked to an asynchronous 1 Hz mark, with holdover
module pps_timebase #(
  parameter int unsigned NOM_TICKS = 125_000_000,
  parameter int unsigned WINDOW    = 12_500,
  parameter int unsigned PULSE_W   = 16
) (
  input  logic        clk125,
  input  logic        rst,
  input  logic        t1hz_in,
  input  logic        ext_flag_in,
  input  logic [31:0] sec_load_val,
  input  logic        sec_load_req,
  output logic        sec_load_ack,
  output logic [31:0] sec_cnt,
  output logic [26:0] subsec_cnt,
  output logic        pps_pulse,
  output logic [31:0] period_cnt,
  output logic        period_valid,
  output logic [15:0] glitch_cnt,
  output logic [1:0]  state,
  output logic        src_ext
);

  localparam logic [31:0] NOM32      = 32'(NOM_TICKS);
  localparam logic [31:0] WIN32      = 32'(WINDOW);
  localparam logic [31:0] ACQ_LIMIT  = 32'(NOM_TICKS + WINDOW);
  localparam logic [31:0] LOCK_LIMIT = 32'(NOM_TICKS + WINDOW + 1);
  localparam logic [26:0] SUB_LAST   = 27'(NOM_TICKS - 1);
  localparam logic [26:0] SUB_EARLY  = 27'(NOM_TICKS - WINDOW);
  localparam logic [26:0] SUB_LATE   = 27'(WINDOW);
  localparam int          PW_BITS    = $clog2(PULSE_W + 1);
  localparam logic [PW_BITS-1:0] PW_LOAD = PW_BITS'(PULSE_W);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACQ      = 2'd1,
    ST_LOCKED   = 2'd2,
    ST_HOLDOVER = 2'd3
  } state_t;

  state_t st_q, st_d;

  logic [2:0]         t1_sync;
  logic [1:0]         ext_sync;
  logic               mark;
  logic [31:0]        tick_cnt;
  logic [31:0]        meas;
  logic [31:0]        dev;
  logic               good;
  logic               sub_wrap;
  logic               boundary;
  logic               sub_clr;
  logic               tick_keep;
  logic               glitch_inc;
  logic               load_go;
  logic [PW_BITS-1:0] pulse_left;

  always_ff @(posedge clk125) begin
    if (rst) begin
      t1_sync  <= '0;
      ext_sync <= '0;
    end else begin
      t1_sync  <= {t1_sync[1:0], t1hz_in};
      ext_sync <= {ext_sync[0], ext_flag_in};
    end
  end

  assign mark     = t1_sync[1] & ~t1_sync[2];
  assign meas     = (&tick_cnt) ? tick_cnt : tick_cnt + 32'd1;
  assign dev      = (meas >= NOM32) ? (meas - NOM32) : (NOM32 - meas);
  assign good     = mark && (dev <= WIN32);
  assign sub_wrap = (subsec_cnt == SUB_LAST);

  always_ff @(posedge clk125) begin
    if (rst) st_q <= ST_IDLE;
    else     st_q <= st_d;
  end

  // A good mark landing just after an internal wrap only realigns: that second was already counted.
  always_comb begin
    st_d       = st_q;
    boundary   = 1'b0;
    sub_clr    = 1'b0;
    tick_keep  = 1'b0;
    glitch_inc = 1'b0;
    case (st_q)
      ST_IDLE: begin
        if (mark) begin
          sub_clr = 1'b1;
          st_d    = ST_ACQ;
        end
      end
      ST_ACQ: begin
        if (good) begin
          sub_clr  = 1'b1;
          boundary = (subsec_cnt > SUB_LATE);
          st_d     = ST_LOCKED;
        end else if (mark) begin
          sub_clr = 1'b1;
        end else begin
          boundary = sub_wrap;
          if (tick_cnt >= ACQ_LIMIT) st_d = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        if (good) begin
          sub_clr  = 1'b1;
          boundary = (subsec_cnt > SUB_LATE);
        end else begin
          // Rejected marks leave the period reference on the last accepted mark.
          if (mark) begin
            glitch_inc = 1'b1;
            tick_keep  = 1'b1;
          end
          boundary = sub_wrap;
          if (tick_cnt >= LOCK_LIMIT) st_d = ST_HOLDOVER;
        end
      end
      ST_HOLDOVER: begin
        if (mark) begin
          sub_clr = 1'b1;
          if (subsec_cnt >= SUB_EARLY) begin
            boundary = 1'b1;
            st_d     = ST_LOCKED;
          end else if (subsec_cnt <= SUB_LATE) begin
            st_d = ST_LOCKED;
          end else begin
            glitch_inc = 1'b1;
            st_d       = ST_ACQ;
          end
        end else begin
          boundary = sub_wrap;
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  assign load_go = boundary && sec_load_req && !sec_load_ack;

  always_ff @(posedge clk125) begin
    if (rst) begin
      tick_cnt     <= '0;
      period_cnt   <= '0;
      period_valid <= 1'b0;
      subsec_cnt   <= '0;
      sec_cnt      <= '0;
      sec_load_ack <= 1'b0;
      glitch_cnt   <= '0;
      pulse_left   <= '0;
    end else begin
      if (mark && !tick_keep)  tick_cnt <= '0;
      else if (!(&tick_cnt))   tick_cnt <= tick_cnt + 32'd1;

      period_valid <= mark;
      if (mark) period_cnt <= meas;

      if (sub_clr)              subsec_cnt <= '0;
      else if (st_q != ST_IDLE) subsec_cnt <= sub_wrap ? 27'd0 : subsec_cnt + 27'd1;

      if (load_go)       sec_cnt <= sec_load_val;
      else if (boundary) sec_cnt <= sec_cnt + 32'd1;

      if (load_go)            sec_load_ack <= 1'b1;
      else if (!sec_load_req) sec_load_ack <= 1'b0;

      if (glitch_inc && !(&glitch_cnt)) glitch_cnt <= glitch_cnt + 16'd1;

      if (boundary)                 pulse_left <= PW_LOAD;
      else if (pulse_left != '0)    pulse_left <= pulse_left - 1'b1;
    end
  end

  assign pps_pulse = (pulse_left != '0);
  assign state     = st_q;
  assign src_ext   = ext_sync[1] && (st_q == ST_LOCKED);

endmodule

// File: tb/tb_pps_timebase.sv
// tb/tb_pps_timebase.sv - randomized bench for pps_timebase against a cycle-stamp timebase model
module tb_pps_timebase;
  localparam int NOM = 1000;
  localparam int WIN = 10;
  localparam int PW  = 4;

  logic        clk125 = 1'b0;
  logic        rst = 1'b1;
  logic        t1hz_in = 1'b0;
  logic        ext_flag_in = 1'b0;
  logic [31:0] sec_load_val = '0;
  logic        sec_load_req = 1'b0;
  logic        sec_load_ack;
  logic [31:0] sec_cnt;
  logic [26:0] subsec_cnt;
  logic        pps_pulse;
  logic [31:0] period_cnt;
  logic        period_valid;
  logic [15:0] glitch_cnt;
  logic [1:0]  state;
  logic        src_ext;

  pps_timebase #(.NOM_TICKS(NOM), .WINDOW(WIN), .PULSE_W(PW)) dut (
    .clk125(clk125), .rst(rst), .t1hz_in(t1hz_in), .ext_flag_in(ext_flag_in),
    .sec_load_val(sec_load_val), .sec_load_req(sec_load_req), .sec_load_ack(sec_load_ack),
    .sec_cnt(sec_cnt), .subsec_cnt(subsec_cnt), .pps_pulse(pps_pulse),
    .period_cnt(period_cnt), .period_valid(period_valid), .glitch_cnt(glitch_cnt),
    .state(state), .src_ext(src_ext)
  );

  always #4 clk125 = ~clk125;

  int n_cmp = 0;
  int n_bad = 0;
  int pps_total = 0;

  // Model: everything is expressed as cycle stamps (last tick clear, last subsec origin, last boundary).
  int          m_n, m_tref, m_sref, m_frozen, m_lastb, m_state, m_sub, m_glitch;
  logic [31:0] m_sec, m_period;
  bit          m_ack, m_pv, m_src;
  bit          p1, p2, p3, e_prev;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic lit(input string name, input logic [63:0] act, input logic [63:0] mexp,
                     input logic [63:0] exp);
    chk(name, act, exp);
    chk({"model_", name}, mexp, exp);
  endtask

  task automatic step();
    logic        r_rst, r_t1, r_ext, r_req;
    logic [31:0] r_val;
    int          n, tick_pre, ss, per, nxt;
    bit          mk, good, bnd;
    @(posedge clk125);
    r_rst = rst; r_t1 = t1hz_in; r_ext = ext_flag_in; r_req = sec_load_req; r_val = sec_load_val;
    #1;
    if (r_rst) begin
      m_n = 0; m_tref = 0; m_sref = 0; m_frozen = 0; m_lastb = -1000; m_state = 0;
      m_glitch = 0; m_sec = '0; m_period = '0; m_ack = 0; m_pv = 0; m_src = 0;
      p1 = 0; p2 = 0; p3 = 0; e_prev = 0;
    end else begin
      m_n++;
      n        = m_n;
      mk       = p2 & ~p3;
      tick_pre = n - 1 - m_tref;
      ss       = (n - 1 - m_sref) % NOM;
      per      = n - m_tref;
      good     = mk && (per >= NOM - WIN) && (per <= NOM + WIN);
      bnd      = 0;
      nxt      = m_state;
      m_pv     = mk;
      if (mk) m_period = per;
      case (m_state)
        0: if (mk) begin m_sref = n; nxt = 1; end
        1: begin
          if (good) begin bnd = ss > WIN; m_sref = n; nxt = 2; end
          else if (mk) m_sref = n;
          else begin bnd = (ss == NOM - 1); if (tick_pre >= NOM + WIN) nxt = 0; end
        end
        2: begin
          if (good) begin bnd = ss > WIN; m_sref = n; end
          else begin
            if (mk && m_glitch < 65535) m_glitch++;
            bnd = (ss == NOM - 1);
            if (tick_pre >= NOM + WIN + 1) nxt = 3;
          end
        end
        default: begin
          if (mk) begin
            m_sref = n;
            if (ss >= NOM - WIN) begin bnd = 1; nxt = 2; end
            else if (ss <= WIN) nxt = 2;
            else begin nxt = 1; if (m_glitch < 65535) m_glitch++; end
          end else bnd = (ss == NOM - 1);
        end
      endcase
      if (mk && !(m_state == 2 && !good)) m_tref = n;
      if (nxt == 0 && m_state != 0) m_frozen = (n - m_sref) % NOM;
      if (bnd && r_req && !m_ack) begin
        m_sec = r_val; m_ack = 1;
      end else begin
        if (bnd) m_sec = m_sec + 32'd1;
        if (!r_req) m_ack = 0;
      end
      if (bnd) m_lastb = n;
      m_state = nxt;
      m_src   = e_prev && (nxt == 2);
      e_prev  = r_ext;
      p3 = p2; p2 = p1; p1 = r_t1;
    end
    m_sub = (m_state == 0) ? m_frozen : (m_n - m_sref) % NOM;
    if (pps_pulse) pps_total++;
    chk("state", state, m_state);
    chk("sec_cnt", sec_cnt, m_sec);
    chk("subsec_cnt", subsec_cnt, m_sub);
    chk("pps_pulse", pps_pulse, (m_n - m_lastb) < PW);
    chk("period_cnt", period_cnt, m_period);
    chk("period_valid", period_valid, m_pv);
    chk("glitch_cnt", glitch_cnt, m_glitch);
    chk("sec_load_ack", sec_load_ack, m_ack);
    chk("src_ext", src_ext, m_src);
    @(negedge clk125);
  endtask

  task automatic idle(input int c);
    repeat (c) begin t1hz_in = 1'b0; step(); end
  endtask

  task automatic mark();
    repeat (20) begin t1hz_in = 1'b1; step(); end
  endtask

  task automatic wait_sub(input int target);
    int k = 0;
    while (m_sub != target && m_state != 0 && k < 3000) begin
      t1hz_in = 1'b0; step(); k++;
    end
    n_cmp++;
    if (k >= 3000) begin
      n_bad++;
      $display("FAIL wait_sub: no subsec %0d within %0d cycles", target, k);
    end
  endtask

  initial begin
    int pps_base, kind, gap;
    @(negedge clk125);
    repeat (5) step();
    chk("rst_state", state, 0);
    chk("rst_sec", sec_cnt, 0);
    chk("rst_subsec", subsec_cnt, 0);
    chk("rst_period", period_cnt, 0);
    chk("rst_glitch", glitch_cnt, 0);
    chk("rst_ack", sec_load_ack, 0);
    chk("rst_pps", pps_pulse, 0);

    rst = 1'b0; ext_flag_in = 1'b1;
    idle(50);
    repeat (4) begin mark(); idle(980); end
    pps_base = pps_total;
    mark();
    lit("acq_sec", sec_cnt, m_sec, 4);
    lit("acq_period", period_cnt, m_period, 1000);
    lit("acq_state", state, m_state, 2);
    chk("acq_pps_width", pps_total - pps_base, PW);
    chk("acq_src_ext", src_ext, 1);

    idle(480); mark();
    lit("glitch_cnt", glitch_cnt, m_glitch, 1);
    lit("glitch_sec", sec_cnt, m_sec, 4);
    idle(480); mark();
    lit("after_glitch_sec", sec_cnt, m_sec, 5);
    lit("after_glitch_period", period_cnt, m_period, 1000);
    lit("after_glitch_state", state, m_state, 2);

    idle(3100);
    lit("hold_state", state, m_state, 3);
    lit("hold_sec", sec_cnt, m_sec, 8);
    wait_sub(992); mark();
    lit("early_relock_state", state, m_state, 2);
    lit("early_relock_sec", sec_cnt, m_sec, 9);

    idle(1500); wait_sub(3);
    t1hz_in = 1'b1; step(); step(); step();
    lit("late_relock_subsec", subsec_cnt, m_sub, 0);
    lit("late_relock_state", state, m_state, 2);
    lit("late_relock_sec", sec_cnt, m_sec, 11);
    repeat (17) step();

    sec_load_val = 32'h1234_5678; sec_load_req = 1'b1;
    idle(1100);
    lit("load_sec", sec_cnt, m_sec, 32'h1234_5678);
    chk("load_ack", sec_load_ack, 1);
    lit("load_state", state, m_state, 3);
    sec_load_req = 1'b0; step();
    chk("load_ack_drop", sec_load_ack, 0);

    sec_load_val = 32'hCAFE_0001; sec_load_req = 1'b1;
    idle(100);
    chk("pending_ack", sec_load_ack, 0);
    rst = 1'b1; step(); step();
    lit("rst_mid_state", state, m_state, 0);
    lit("rst_mid_sec", sec_cnt, m_sec, 0);
    chk("rst_mid_ack", sec_load_ack, 0);
    chk("rst_mid_subsec", subsec_cnt, 0);
    chk("rst_mid_src", src_ext, 0);
    rst = 1'b0; sec_load_req = 1'b0;

    for (int i = 0; i < 40; i++) begin
      ext_flag_in = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: begin sec_load_req = 1'b1; sec_load_val = $urandom; end
        1: sec_load_req = 1'b0;
        default: ;
      endcase
      if (i == 20) begin rst = 1'b1; step(); step(); rst = 1'b0; end
      kind = int'($urandom_range(0, 9));
      if (kind == 9 && m_state != 0) begin
        idle(int'($urandom_range(1100, 1900)));
        wait_sub((980 + int'($urandom_range(0, 40))) % NOM);
        mark();
      end else begin
        if (kind <= 5)      gap = 988 + int'($urandom_range(0, 24));
        else if (kind == 6) gap = int'($urandom_range(300, 900));
        else if (kind == 7) gap = int'($urandom_range(1011, 1040));
        else                gap = int'($urandom_range(1200, 2600));
        mark();
        idle(gap - 20);
      end
    end
    idle(50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
